// File: rtl/truth_table_sweeper_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_if
//   Groups the sweep handshake and the truth-table result bus shared between
//   the truth_table_sweeper and whatever requests sweeps and reads results.
//
//   Signals:
//     start     request a sweep
//     f_in      expression output for the vector currently on vec
//     vec       input vector driven to the expression block
//     busy      sweep in progress
//     done      sweep complete, results valid
//     minterms  bit i = sampled f_in for vec == i
//     ones      number of set bits in minterms
//   With SWEEP_COMPARE_EN defined, additionally:
//     expected  reference truth table, stable for the whole sweep
//     mismatch  sticky flag, set on any row where f_in != expected[vec]
//     first_bad vec of the first mismatching row (0 if none)
//
//   Modports: slave = the sweeper, master = the host/expression side.
// ---------------------------------------------------------------------------
interface truth_table_sweeper_if #(
    parameter int N_VARS = 4
);
    logic                       start;
    logic                       f_in;
    logic [N_VARS-1:0]          vec;
    logic                       busy;
    logic                       done;
    logic [(1 << N_VARS)-1:0]   minterms;
    logic [N_VARS:0]            ones;
`ifdef SWEEP_COMPARE_EN
    logic [(1 << N_VARS)-1:0]   expected;
    logic                       mismatch;
    logic [N_VARS-1:0]          first_bad;

    modport slave  (input  start, f_in, expected,
                    output vec, busy, done, minterms, ones, mismatch, first_bad);
    modport master (output start, f_in, expected,
                    input  vec, busy, done, minterms, ones, mismatch, first_bad);
`else
    modport slave  (input  start, f_in,
                    output vec, busy, done, minterms, ones);
    modport master (output start, f_in,
                    input  vec, busy, done, minterms, ones);
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//   Walks an N_VARS-bit vector through 0 .. 2^N_VARS-1, holds each value for
//   SETTLE cycles, samples the expression output on the last held cycle and
//   assembles the truth table as a minterm mask plus a count of true rows.
//
//   Parameters:
//     N_VARS  number of expression inputs (1..4); vec[N_VARS-1] is the MSB
//     SETTLE  cycles each vector is held before sampling (1..15)
//
//   Ports:
//     clk    single clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset
//     bus    truth_table_sweeper_if.slave (start, f_in, vec, busy, done,
//            minterms, ones; plus expected/mismatch/first_bad when the
//            compare option is built)
//
//   Build option:
//     SWEEP_COMPARE_EN  adds a comparison of every sampled row against
//                       bus.expected, reported via mismatch / first_bad.
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);
    localparam int                ROWS     = 1 << N_VARS;
    localparam logic [3:0]        RELOAD   = 4'(SETTLE - 1);
    localparam logic [N_VARS-1:0] LAST_VEC = {N_VARS{1'b1}};

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_VARS-1:0]   vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ROWS-1:0]     minterms_q, minterms_d;
    logic [N_VARS:0]     ones_q, ones_d;
`ifdef SWEEP_COMPARE_EN
    logic                mismatch_q, mismatch_d;
    logic [N_VARS-1:0]   first_bad_q, first_bad_d;
`endif

    // NOTE: reset is sampled on the clock edge only (synchronous), so it
    // lives inside the clocked branch rather than in the sensitivity list.
    // NOTE: all registered state uses non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            minterms_q  <= '0;
            ones_q      <= '0;
`ifdef SWEEP_COMPARE_EN
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            minterms_q  <= minterms_d;
            ones_q      <= ones_d;
`ifdef SWEEP_COMPARE_EN
            mismatch_q  <= mismatch_d;
            first_bad_q <= first_bad_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        minterms_d  = minterms_q;
        ones_d      = ones_q;
`ifdef SWEEP_COMPARE_EN
        mismatch_d  = mismatch_q;
        first_bad_d = first_bad_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = HOLD;
                    vec_d       = '0;
                    cnt_d       = RELOAD;
                    minterms_d  = '0;
                    ones_d      = '0;
`ifdef SWEEP_COMPARE_EN
                    mismatch_d  = 1'b0;
                    first_bad_d = '0;
`endif
                end
            end
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Last settle cycle for this vector: capture the row.
                    minterms_d[vec_q] = bus.f_in;
                    ones_d            = ones_q + (N_VARS + 1)'(bus.f_in);
`ifdef SWEEP_COMPARE_EN
                    if (bus.f_in != bus.expected[vec_q]) begin
                        mismatch_d = 1'b1;
                        if (!mismatch_q) first_bad_d = vec_q;
                    end
`endif
                    // Terminal test comes before the increment, so vec never
                    // wraps and keeps the last row value in DONE.
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + N_VARS'(1);
                        cnt_d = RELOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vec      = vec_q;
    assign bus.busy     = (state_q == HOLD);
    assign bus.done     = (state_q == DONE);
    assign bus.minterms = minterms_q;
    assign bus.ones     = ones_q;
`ifdef SWEEP_COMPARE_EN
    assign bus.mismatch  = mismatch_q;
    assign bus.first_bad = first_bad_q;
`endif

endmodule
